// File: rtl/csa_operand_loader.sv
// Serial operand loader for the 4-operand carry-save adder: packs four W-bit
// operands into a1..d1, lets the external adder settle for one cycle, then registers its result.
module csa_operand_loader #(
  parameter int W    = 3,
  parameter int NOPS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         clear,
  output logic [W-1:0] a1,
  output logic [W-1:0] b1,
  output logic [W-1:0] c1,
  output logic [W-1:0] d1,
  input  logic [W:0]   csa_sum,
  input  logic         csa_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W+1:0] res_data,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Both streams use valid/ready: a beat transfers on a rising edge where valid and
  // ready are both high; valid never waits on ready, and a producer holds its data until the transfer.

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  generate
    if (NOPS != 4) begin : g_bad_nops
      $error("csa_operand_loader: NOPS must be 4 for the 4-operand adder");
    end
  endgenerate

  state_t       state_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic [W-1:0] ops_q [NOPS];
  logic [W+1:0] res_q;
  logic         res_valid_q;
  logic         accept;

  assign in_ready = ~rst & (state_q == FILL);
  assign accept   = in_valid & in_ready & ~clear;
  assign count_d  = count_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      count_q     <= 2'd0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      for (int i = 0; i < NOPS; i++) begin
        ops_q[i] <= '0;
      end
    end else if (clear) begin
      // Abort keeps operand slots and the last result; only control state is dropped.
      state_q     <= FILL;
      count_q     <= 2'd0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            ops_q[count_q] <= in_data;
            count_q        <= count_d;
            if (count_q == 2'(NOPS - 1)) begin
              state_q <= EVAL;
            end
          end
        end
        EVAL: begin
          res_q       <= {csa_cout, csa_sum};
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= FILL;
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign a1        = ops_q[0];
  assign b1        = ops_q[1];
  assign c1        = ops_q[2];
  assign d1        = ops_q[3];
  assign res_data  = res_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != FILL) || (count_q != 2'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_csa_operand_loader.sv
// Bench for csa_operand_loader: behavioural adder, cycle reference model with
// a result scoreboard, directed scenarios and a randomized phase.
module tb_csa_operand_loader;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         clear;
  logic [W-1:0] a1, b1, c1, d1;
  logic [W:0]   csa_sum;
  logic         csa_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W+1:0] res_data;
  logic         busy;
  logic [1:0]   dbg_state;
  logic [W+1:0] adder_out;

  csa_operand_loader #(.W(W), .NOPS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .a1        (a1),
    .b1        (b1),
    .c1        (c1),
    .d1        (d1),
    .csa_sum   (csa_sum),
    .csa_cout  (csa_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Stand-in for the combinational carry-save adder.
  assign adder_out = {2'b00, a1} + {2'b00, b1} + {2'b00, c1} + {2'b00, d1};
  assign csa_sum   = adder_out[W:0];
  assign csa_cout  = adder_out[W+1];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];
  int           got_q[$];
  int           m_grp[$];
  logic [W-1:0] m_ops [4] = '{default: '0};
  logic [W+1:0] m_res  = '0;
  logic [W+1:0] m_sum  = '0;
  logic [W+1:0] dut_res_s = '0;
  bit           m_eval = 0;
  bit           m_rv   = 0;
  bit           m_acc  = 0;
  bit           chk_en = 0;
  bit           rand_rr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: operands collect into a group; a full group yields its sum
  // one cycle later, which then waits until consumed.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      m_acc = 0;
      if (rst) begin
        m_ops  = '{default: '0};
        m_grp.delete();
        exp_q.delete();
        m_eval = 0;
        m_rv   = 0;
        m_res  = '0;
      end else if (clear) begin
        m_grp.delete();
        exp_q.delete();
        m_eval = 0;
        m_rv   = 0;
      end else if (m_rv) begin
        if (res_ready) begin
          if (exp_q.size() == 0) check("res_unexpected", 1, 0);
          else check("res_order", dut_res_s, exp_q.pop_front());
          got_q.push_back(int'(dut_res_s));
          m_rv = 0;
        end
      end else if (m_eval) begin
        m_eval = 0;
        m_rv   = 1;
        m_res  = m_sum;
      end else if (in_valid) begin
        m_ops[m_grp.size()] = in_data;
        m_grp.push_back(int'(in_data));
        m_acc = 1;
        if (m_grp.size() == 4) begin
          m_sum = (W+2)'(m_grp[0] + m_grp[1] + m_grp[2] + m_grp[3]);
          exp_q.push_back(m_sum);
          m_eval = 1;
          m_grp.delete();
        end
      end
    end
  end

  // Per-cycle output checks, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      dut_res_s = res_data;
      if (chk_en) begin
        check("in_ready", in_ready, !rst && !m_eval && !m_rv);
        check("res_valid", res_valid, m_rv);
        check("res_data", res_data, m_res);
        check("a1", a1, m_ops[0]);
        check("b1", b1, m_ops[1]);
        check("c1", c1, m_ops[2]);
        check("d1", d1, m_ops[3]);
        check("busy", busy, m_eval || m_rv || (m_grp.size() != 0));
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic send(input logic [W-1:0] v, input int gap);
    bit done;
    in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (rand_rr) res_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b1;
    in_data  = v;
    done     = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (rand_rr) res_ready = 1'($urandom_range(0, 1));
      if (m_acc) done = 1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_group(input int x0, input int x1, input int x2, input int x3);
    send(W'(x0), 0);
    send(W'(x1), 0);
    send(W'(x2), 0);
    send(W'(x3), 0);
  endtask

  task automatic wait_hold();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (m_rv) done = 1;
    end
    if (!done) check("hold_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!m_rv && !m_eval && m_grp.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ops", {a1, b1, c1, d1}, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_en = 1;

    // max operands, immediate consume
    send_group(7, 7, 7, 7);
    drain();
    check("t1_count", got_q.size(), 1);
    check("t1_res", got_q.size() > 0 ? got_q[0] : -1, 28);
    got_q.delete();

    // gaps plus backpressure; in_valid held during HOLD must not be taken
    res_ready = 1'b0;
    send(3'd1, $urandom_range(0, 3));
    send(3'd2, $urandom_range(0, 3));
    send(3'd3, $urandom_range(0, 3));
    send(3'd4, $urandom_range(0, 3));
    wait_hold();
    in_valid = 1'b1; in_data = 3'd6;
    repeat (5) @(negedge clk);
    in_valid = 1'b0; res_ready = 1'b1;
    drain();
    check("t2_count", got_q.size(), 1);
    check("t2_res", got_q.size() > 0 ? got_q[0] : -1, 10);
    got_q.delete();

    // two groups in order, slots overwritten
    send_group(0, 0, 0, 5);
    send_group(3, 0, 6, 1);
    drain();
    check("t3_count", got_q.size(), 2);
    check("t3_res0", got_q.size() > 0 ? got_q[0] : -1, 5);
    check("t3_res1", got_q.size() > 1 ? got_q[1] : -1, 10);
    got_q.delete();

    // clear drops a partial group
    send(3'd2, 0);
    send(3'd2, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t4_busy_after_clear", busy, 0);
    send_group(1, 1, 1, 1);
    drain();
    check("t4_count", got_q.size(), 1);
    check("t4_res", got_q.size() > 0 ? got_q[0] : -1, 4);
    got_q.delete();

    // asynchronous reset while holding a result
    res_ready = 1'b0;
    send_group(7, 7, 7, 7);
    wait_hold();
    check("t5_pre_res", res_data, 28);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_res_valid", res_valid, 0);
    check("t5_rst_res_data", res_data, 0);
    check("t5_rst_ops", {a1, b1, c1, d1}, 0);
    check("t5_rst_in_ready", in_ready, 0);
    @(negedge clk);
    #2 rst = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    send_group(6, 5, 4, 3);
    drain();
    check("t5_count", got_q.size(), 1);
    check("t5_res", got_q.size() > 0 ? got_q[0] : -1, 18);
    got_q.delete();

    // 4th operand coincides with clear
    send(3'd4, 0);
    send(3'd4, 0);
    send(3'd4, 0);
    in_valid = 1'b1; in_data = 3'd4; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_result", got_q.size() + int'(m_rv), 0);
    send_group(1, 2, 1, 2);
    drain();
    check("t6_count", got_q.size(), 1);
    check("t6_res", got_q.size() > 0 ? got_q[0] : -1, 6);
    got_q.delete();

    // randomized groups, gaps and backpressure
    rand_rr = 1;
    for (int g = 0; g < 25; g++) begin
      for (int k = 0; k < 4; k++) begin
        send(W'($urandom_range(0, 7)), $urandom_range(0, 3));
      end
    end
    rand_rr = 0;
    res_ready = 1'b1;
    drain();
    check("rand_count", got_q.size(), 25);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
